// File: rtl/fifo_pkg.sv
// Shared definitions for the shift-register FIFO: count width helper and the
// per-stage select encoding.
package fifo_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_IN   = 2'b01;
    localparam logic [1:0] SEL_PREV = 2'b10;
    localparam logic [1:0] SEL_CLR  = 2'b11;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_cell.sv
// One FIFO stage: a data/valid register pair that holds, loads the write word,
// loads its upstream neighbour, or clears.
module fifo_cell
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] prev_data_i,
    input  logic             prev_valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        unique case (sel_i)
            SEL_HOLD: begin
                data_d  = data_q;
                valid_d = valid_q;
            end
            SEL_IN: begin
                data_d  = data_i;
                valid_d = 1'b1;
            end
            SEL_PREV: begin
                data_d  = prev_data_i;
                valid_d = prev_valid_i;
            end
            SEL_CLR: begin
                data_d  = '0;
                valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/shift_fifo_ctl.sv
// Compacting shift-register FIFO: stage 0 is always the head, with occupancy
// count, programmable almost flags and sticky overflow/underflow.
module shift_fifo_ctl
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1,
    parameter int unsigned CNT_W    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_in,
    input  logic             shift_out,
    input  logic             err_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    if (DEPTH < 2 || AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_bad_params
        $error("shift_fifo_ctl: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AfC    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AeC    = CNT_W'(AE_LEVEL);

    logic [CNT_W-1:0] count_d, count_q;
    logic             overflow_d, overflow_q;
    logic             underflow_d, underflow_q;
    logic             rd, wr;
    logic [CNT_W-1:0] wr_idx;
    logic [1:0]       sel [DEPTH];
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] valid_mask;

    assign empty        = (count_q == '0);
    assign full         = (count_q == DepthC);
    assign almost_full  = (count_q >= AfC);
    assign almost_empty = (count_q <= AeC);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign data_out     = stage_data[0];

    assign rd = shift_out & ~empty;
    assign wr = shift_in & (~full | shift_out);
    // Slot the new word lands in, after any simultaneous pop has compacted the chain.
    assign wr_idx = count_q - CNT_W'(rd);

    always_comb begin
        count_d     = count_q + CNT_W'(wr) - CNT_W'(rd);
        overflow_d  = (shift_in & full & ~shift_out) | (overflow_q & ~err_clr);
        underflow_d = (shift_out & empty) | (underflow_q & ~err_clr);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = SEL_HOLD;
            if (wr && wr_idx == CNT_W'(i)) begin
                sel[i] = SEL_IN;
            end else if (rd) begin
                sel[i] = (i == DEPTH - 1) ? SEL_CLR : SEL_PREV;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] up_data;
        logic             up_valid;
        if (g == DEPTH - 1) begin : g_top
            assign up_data  = '0;
            assign up_valid = 1'b0;
        end else begin : g_mid
            assign up_data  = stage_data[g+1];
            assign up_valid = stage_valid[g+1];
        end

        fifo_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk         (clk),
            .reset_n     (reset_n),
            .sel_i       (sel[g]),
            .data_i      (data_in),
            .prev_data_i (up_data),
            .prev_valid_i(up_valid),
            .data_o      (stage_data[g]),
            .valid_o     (stage_valid[g])
        );
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_mask[i] = (CNT_W'(i) < count_q);
        end
    end

    // Valid stages must stay packed from stage 0 and agree with the counter.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (stage_valid == valid_mask)
            else $error("shift_fifo_ctl: stage valid bits not contiguous with count");
        end
    end

endmodule

// File: tb/tb_shift_fifo_ctl.sv
// Directed bench for shift_fifo_ctl with a queue scoreboard of accepted words
// and a reference occupancy/flag model.
module tb_shift_fifo_ctl;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AFL   = 3;
    localparam int unsigned AEL   = 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] data_in;
    logic             shift_in, shift_out, err_clr;
    logic [WIDTH-1:0] data_out;
    logic             empty, full, almost_full, almost_empty;
    logic [CW-1:0]    count;
    logic             overflow, underflow;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] sb[$];
    logic             ovf_m, udf_m;

    shift_fifo_ctl #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AFL),
        .AE_LEVEL(AEL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data_in     (data_in),
        .shift_in    (shift_in),
        .shift_out   (shift_out),
        .err_clr     (err_clr),
        .data_out    (data_out),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        int n;
        n = sb.size();
        chk({tag, ".count"}, WIDTH'(count), WIDTH'(n));
        chk({tag, ".empty"}, WIDTH'(empty), WIDTH'(n == 0));
        chk({tag, ".full"}, WIDTH'(full), WIDTH'(n == DEPTH));
        chk({tag, ".afull"}, WIDTH'(almost_full), WIDTH'(n >= AFL));
        chk({tag, ".aempty"}, WIDTH'(almost_empty), WIDTH'(n <= AEL));
        chk({tag, ".ovf"}, WIDTH'(overflow), WIDTH'(ovf_m));
        chk({tag, ".udf"}, WIDTH'(underflow), WIDTH'(udf_m));
        if (n > 0) chk({tag, ".head"}, data_out, sb[0]);
    endtask

    // Drive one cycle of stimulus; the scoreboard is updated with what the
    // FIFO must accept and the popped word is compared against its head.
    task automatic step(input string tag, input logic si, input logic so,
                        input logic [WIDTH-1:0] din, input logic clr);
        bit m_full, m_empty, m_rd, m_wr;
        shift_in  = si;
        shift_out = so;
        data_in   = din;
        err_clr   = clr;
        m_empty   = (sb.size() == 0);
        m_full    = (sb.size() == DEPTH);
        m_rd      = so && !m_empty;
        m_wr      = si && (!m_full || so);
        if (m_rd) chk({tag, ".pop"}, data_out, sb[0]);
        @(posedge clk);
        #1;
        ovf_m = (si && m_full && !so) || (ovf_m && !clr);
        udf_m = (so && m_empty) || (udf_m && !clr);
        if (m_rd) void'(sb.pop_front());
        if (m_wr) sb.push_back(din);
        shift_in  = 1'b0;
        shift_out = 1'b0;
        err_clr   = 1'b0;
        chk_state(tag);
    endtask

    task automatic model_reset();
        sb.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        shift_in  = 1'b1;
        shift_out = 1'b0;
        err_clr   = 1'b0;
        data_in   = 32'hFFFF_FFFF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset");
        chk("reset.dout", data_out, 32'h0);
        reset_n  = 1'b1;
        shift_in = 1'b0;

        // Fill then drain in order.
        step("push11", 1, 0, 32'h11, 0);
        step("push22", 1, 0, 32'h22, 0);
        step("push33", 1, 0, 32'h33, 0);
        step("push44", 1, 0, 32'h44, 0);
        repeat (4) step("drain_a", 0, 1, 32'h0, 0);

        // Overflow at full: dropped word never appears.
        step("f11", 1, 0, 32'h11, 0);
        step("f22", 1, 0, 32'h22, 0);
        step("f33", 1, 0, 32'h33, 0);
        step("f44", 1, 0, 32'h44, 0);
        step("ovf55", 1, 0, 32'h55, 0);
        repeat (4) step("drain_b", 0, 1, 32'h0, 0);
        step("clr_ovf", 0, 0, 32'h0, 1);

        // Simultaneous push/pop at full.
        step("g11", 1, 0, 32'h11, 0);
        step("g22", 1, 0, 32'h22, 0);
        step("g33", 1, 0, 32'h33, 0);
        step("g44", 1, 0, 32'h44, 0);
        step("pp66", 1, 1, 32'h66, 0);
        chk("pp66.dout22", data_out, 32'h22);
        repeat (4) step("drain_c", 0, 1, 32'h0, 0);

        // Underflow, clear, and error-beats-clear.
        step("udf", 0, 1, 32'h0, 0);
        step("udf_clr", 0, 0, 32'h0, 1);
        step("udf_race", 0, 1, 32'h0, 1);
        step("udf_clr2", 0, 0, 32'h0, 1);

        // Push into empty with shift_out: write accepted, underflow set.
        step("pe88", 1, 1, 32'h88, 0);
        step("mix99", 1, 1, 32'h99, 0);
        step("drain_d", 0, 1, 32'h0, 1);

        // Reset mid-operation with count=3 and overflow set.
        step("h1", 1, 0, 32'hA1, 0);
        step("h2", 1, 0, 32'hA2, 0);
        step("h3", 1, 0, 32'hA3, 0);
        step("h4", 1, 0, 32'hA4, 0);
        step("hovf", 1, 0, 32'hA5, 0);
        step("hpop", 0, 1, 32'h0, 0);
        chk("pre_rst.count", WIDTH'(count), 32'd3);
        reset_n  = 1'b0;
        shift_in = 1'b1;
        data_in  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        model_reset();
        reset_n  = 1'b1;
        shift_in = 1'b0;
        chk_state("mid_rst");
        step("push77", 1, 0, 32'h77, 0);
        chk("push77.dout", data_out, 32'h77);
        step("drain_e", 0, 1, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_fifo_ctl.md
Name: shift_fifo_ctl

Overview:
Parametrised synchronous shift-register FIFO built from a chain of per-stage data/valid cells. It succeeds the fixed-depth shift-register FIFO with:
- compacted occupancy tracking, so stage 0 always holds the head;
- an occupancy count;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags.
It sits between pipeline producers and consumers that use the shift_in/shift_out handshake.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 4, number of stages (>=2)
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL
CNT_W, $clog2(DEPTH+1), derived width of count; not overridden

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous reset, active-low
data_in  input  WIDTH  write data
shift_in  input  1  write request
shift_out  input  1  read request; pops the current data_out
err_clr  input  1  clears sticky overflow/underflow flags
data_out  output  WIDTH  head word (stage 0), valid only when empty=0
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  CNT_W  number of valid stages
overflow  output  1  sticky: a write was dropped
underflow  output  1  sticky: a read hit an empty FIFO

Behaviour:
- Only one clock exists. reset_n is synchronous and active-low; it is sampled on the rising edge of clk.
- Reset (reset_n=0 at an edge):
  - all stage valid bits clear; count=0; overflow=0; underflow=0.
  - Therefore empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
  - Stage data registers reset to 0, so data_out=0.
  - Reset has priority over every other input, including mid-operation.
- Storage: stages 0..DEPTH-1, stage 0 is the head. Valid stages are always contiguous from 0, i.e. valid = (1<<count)-1.
- Effective operations each cycle:
  - rd = shift_out & ~empty
  - wr = shift_in & (~full | shift_out)
  - At full, a simultaneous shift_in and shift_out is accepted: pop and push happen in the same cycle.
- Per edge, data movement:
  - rd=1: every stage i loads stage i+1; the top stage loads 0/invalid.
  - wr=1: data_in lands in stage (count - rd).
  - rd=0 and wr=0: all stages hold.
- count_next = count + wr - rd. It never exceeds DEPTH and never wraps below 0.
- Latency: a word written into an empty FIFO appears on data_out one cycle after the write edge. This is registered; there is no combinational bypass from data_in to data_out.
- All flags are decoded combinationally from registered count.
- Error flags:
  - shift_in=1 while full=1 and shift_out=0: data is dropped and overflow is set.
  - shift_out=1 while empty=1: no state change and underflow is set.
  - Push-while-empty with shift_out=1 gives wr=1, rd=0, and underflow is set.
  - err_clr=1 clears both flags. If err_clr and a new error occur in the same cycle, the error wins and the flag stays 1.
- data_out while empty is don't-care for checking. The RTL drives the stage-0 register, which is 0 after a pop-to-empty.
- Illegal parameter combinations (AF_LEVEL>DEPTH, AE_LEVEL>=DEPTH, DEPTH<2) are rejected by an elaboration-time check.

Decomposition:
- Shared package fifo_pkg holds:
  - CNT_W computation function;
  - cell select encoding SEL_HOLD=2'b00, SEL_IN=2'b01, SEL_PREV=2'b10, SEL_CLR=2'b11, kept compatible with the existing stage-select encoding.
- One natural sub-module: fifo_cell (one stage).
  - Inputs: sel, data_in, upstream data/valid, reset_n.
  - Outputs: registered data and valid.
  - Instantiated DEPTH times by a generate loop.
- The top level computes rd, wr and count, and drives per-stage sel from count, rd and wr.

Test Plan (WIDTH=32, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1):
1. Reset with reset_n=0 for 2 cycles while shift_in=1 and data_in=0xFFFFFFFF -> count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0.
2. Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles:
   - count goes 1,2,3,4; almost_full rises at count=3; full=1 at 4.
   - data_out=0x11 one cycle after the first push.
   - Then pop 4 times -> data_out shows 0x22, 0x33, 0x44 in order, then empty=1.
3. While full, push 0x55 with shift_out=0 -> overflow=1, count stays 4. The drain order is still 0x11..0x44.
4. While full, shift_in=1 and shift_out=1 with data_in=0x66 -> count stays 4, data_out becomes 0x22, and 0x66 is the last word drained.
5. When empty, shift_out=1 -> underflow=1, count=0. Then assert err_clr for 1 cycle -> underflow=0. Assert err_clr together with another empty pop -> underflow stays 1.
6. Assert reset_n=0 for one cycle with count=3 and overflow=1 -> next cycle count=0, empty=1, overflow=0. Pushing 0x77 then shows data_out=0x77 one cycle later.
